alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single EX-stage ALU between two requesters: port 0 (EX-stage datapath) and port 1 (branch/address-compare unit). It arbitrates valid/ready requests and drives the ALU for one winner per cycle. The result and flags {Z,N,O,C} are captured in a per-requester response register. Sits in the EX stage, in front of the existing ALU instance.

Parameters:
DATA_W, 32, operand/result width
OP_W, 3, ALU opcode width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 wins ties, subject to the starvation guard
STARVE_MAX, 4, fixed-priority mode only: consecutive port-1 losses before port 1 is forced to win (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle if valid
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req0_op  in  OP_W  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
rsp0_valid  out  1  port 0 response held
rsp0_ready  in  1  port 0 consumes response
rsp0_result  out  DATA_W  registered ALU result
rsp0_flags  out  4  registered {Z,N,O,C}
rsp0_err  out  1  opcode was illegal (100/110/111)
req1_* / rsp1_*  same set as port 0, for port 1
grant  out  2  one-hot: port accepted this cycle (combinational)

Behaviour:
- Reset (async, rst=1):
  - rsp0/1_valid=0, rsp*_result=0, rsp*_flags=0, rsp*_err=0.
  - RR pointer points to port 0 (port 0 has priority on the first contention).
  - Starve counter = 0.
  - Outputs return to these values immediately on rst, including mid-transaction; in-flight responses are dropped.
- Eligibility: portN is eligible when reqN_valid && (!rspN_valid || rspN_ready). Drain and accept in the same cycle is allowed.
- reqN_ready = eligible && port wins arbitration. Exactly 0 or 1 ready per cycle.
- Round-robin (FIXED_PRIO=0):
  - With one eligible port, it wins.
  - With both eligible, the port the RR pointer names wins.
  - After any grant, the pointer moves to the other port.
  - With no grant, the pointer holds.
- Fixed priority (FIXED_PRIO=1):
  - Port 0 wins ties.
  - The starve counter increments each cycle port 1 is eligible and loses; it clears on a port-1 grant or when port 1 is not eligible.
  - When the counter equals STARVE_MAX, port 1 wins the next tie and the counter clears.
- Datapath:
  - Winner's a/b/op are muxed into the ALU combinationally; ALU output is registered.
  - Latency: rspN_valid rises the cycle after reqN_valid && reqN_ready (1 cycle). Throughput is 1 op/cycle total.
- Response hold: rspN_valid stays 1 with stable result/flags/err until rspN_ready=1 with no new acceptance for that port. If drained and refilled in the same cycle, valid stays 1 and the data updates.
- Illegal opcode: the request is still accepted. Result = 0, flags = 0, err = 1. The ALU output is ignored.
- Operands: widths are exact; no sign extension in this block. Overflow and carry come solely from the ALU.
- No requests: the ALU input mux holds 0/0/ADD (deterministic for power and simulation).

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101
  - an is_legal_op function
  - flag bit indices FLG_Z=3, FLG_N=2, FLG_O=1, FLG_C=0
- One sub-module: the existing ALU, instantiated once. Arbitration and response registers are inline.

Test Plan:
- Reset, then port 0 only: ADD a=0x5, b=0x3 → next cycle rsp0_valid=1, result=0x00000008, flags=0000. Hold rsp0_ready=0 for 3 cycles → rsp0 stable and req0_ready=0.
- Both ports valid continuously, RR mode: port 0 SUB 0x0 - 0x1, port 1 ADD 0x7FFFFFFF + 0x1, rsp_ready=1 throughout → grants alternate 01,10,01,...; rsp0 result=0xFFFFFFFF, flags N=1 C=1; rsp1 result=0x80000000, flags N=1 O=1.
- FIXED_PRIO=1, STARVE_MAX=4, both ports valid continuously → port 0 wins 4 cycles, port 1 wins the 5th, and the pattern repeats.
- Port 1 SLT a=0xFFFFFFFF, b=0x1 → result=0x00000001. Then op=3'b110 → result=0, flags=0, err=1.
- Port 0 AND 0xF0F0F0F0 & 0x0F0F0F0F, rsp0_ready=1 in the same cycle as the next accept → result=0, Z=1; rsp0_valid never drops across back-to-back ops.
- Assert rst mid-stream with rsp0_valid=rsp1_valid=1 → both clear immediately. After release, the first contention grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its two-port arbiter:
// opcode encodings, flag bit positions and the opcode legality check.
package alu_pkg;

  // ALU opcode encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Bit positions inside the 4-bit {Z,N,O,C} flag vector
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_O = 1;
  localparam int FLG_C = 0;

  localparam int FLAGS_W = 4;

  // Round-robin pointer: names the port that wins the next tie
  typedef enum logic {
    PRIO_PORT0 = 1'b0,
    PRIO_PORT1 = 1'b1
  } prio_e;

  // Opcodes 100, 110 and 111 are reserved and flagged as errors
  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational EX-stage ALU. Produces the result and {Z,N,O,C} flags.
// Carry on SUB is the unsigned borrow (set when a < b unsigned).
// Logic/compare ops report only Z and N; O and C are zero for them.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [OP_W-1:0]    op,
  output logic [DATA_W-1:0]  result,
  output logic [FLAGS_W-1:0] flags
);

  logic [DATA_W:0]          sum_ext;
  logic [DATA_W:0]          diff_ext;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic                     ovf;
  logic                     carry;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign a_s      = a;
  assign b_s      = b;

  // Opcode decode: select the result and the arithmetic flags
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    carry  = 1'b0;
    case (op[2:0])
      ALU_ADD: begin
        result = sum_ext[DATA_W-1:0];
        carry  = sum_ext[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) &&
                 (sum_ext[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = diff_ext[DATA_W-1:0];
        carry  = diff_ext[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) &&
                 (diff_ext[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: result = '0;
    endcase
  end

  // Flag vector assembly
  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = result[DATA_W-1];
    flags[FLG_O] = ovf;
    flags[FLG_C] = carry;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared EX-stage ALU. Port 0 is the EX
// datapath, port 1 the branch/address-compare unit. One request is granted
// per cycle (round-robin or fixed priority with a starvation guard), the
// winner's operands drive the ALU and the ALU output is captured in that
// port's response register, which holds until the requester consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 3,
  parameter int FIXED_PRIO = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  // port 0 request / response
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [OP_W-1:0]    req0_op,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_result,
  output logic [FLAGS_W-1:0] rsp0_flags,
  output logic               rsp0_err,
  // port 1 request / response
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [OP_W-1:0]    req1_op,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_result,
  output logic [FLAGS_W-1:0] rsp1_flags,
  output logic               rsp1_err,
  // one-hot accept indication, {port1, port0}
  output logic [1:0]         grant
);

  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

  prio_e              rr_ptr;
  logic [3:0]         starve_cnt;

  logic               elig0;
  logic               elig1;
  logic               p1_prio;
  logic               win0;
  logic               win1;

  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [OP_W-1:0]    alu_op;
  logic [DATA_W-1:0]  alu_result;
  logic [FLAGS_W-1:0] alu_flags;

  logic               op_legal;
  logic [DATA_W-1:0]  cap_result;
  logic [FLAGS_W-1:0] cap_flags;
  logic               cap_err;

  // A port can take a new request if its response slot is empty or draining
  assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

  // Port 1 takes a tie either from the RR pointer or from the starvation guard
  assign p1_prio = (FIXED_PRIO != 0) ? (starve_cnt == STARVE_LIM)
                                     : (rr_ptr == PRIO_PORT1);

  assign win1 = elig1 && (!elig0 || p1_prio);
  assign win0 = elig0 && !win1;

  assign req0_ready = win0;
  assign req1_ready = win1;
  assign grant      = {win1, win0};

  // ALU input mux: winner's operands, idle value 0 + 0 ADD when nobody wins
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_W'(ALU_ADD);
    if (win0) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (win1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Reserved opcodes discard the ALU output and report an error instead
  always_comb begin
    op_legal   = is_legal_op(alu_op[2:0]);
    cap_result = op_legal ? alu_result : '0;
    cap_flags  = op_legal ? alu_flags  : '0;
    cap_err    = !op_legal;
  end

  // Round-robin pointer: hand priority to the other port after each grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PRIO_PORT0;
    end else if (win0) begin
      rr_ptr <= PRIO_PORT1;
    end else if (win1) begin
      rr_ptr <= PRIO_PORT0;
    end
  end

  // Starvation guard: count consecutive cycles port 1 is eligible but loses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (FIXED_PRIO == 0) begin
      starve_cnt <= '0;
    end else if (!elig1 || win1) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Port 0 response register: load on accept, clear valid on drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
      rsp0_err    <= 1'b0;
    end else if (win0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= cap_result;
      rsp0_flags  <= cap_flags;
      rsp0_err    <= cap_err;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  // Port 1 response register: load on accept, clear valid on drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
      rsp1_err    <= 1'b0;
    end else if (win1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= cap_result;
      rsp1_flags  <= cap_flags;
      rsp1_err    <= cap_err;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Two instances share the same stimulus:
// dut_rr in round-robin mode and dut_fp in fixed-priority mode with a
// starvation limit of 4. Inputs change 1ns after the rising edge; outputs
// are sampled on the falling edge.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;

  logic         r_req0_ready, r_req1_ready, r_rsp0_valid, r_rsp1_valid;
  logic [W-1:0] r_rsp0_result, r_rsp1_result;
  logic [3:0]   r_rsp0_flags, r_rsp1_flags;
  logic         r_rsp0_err, r_rsp1_err;
  logic [1:0]   r_grant;

  logic         f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
  logic [W-1:0] f_rsp0_result, f_rsp1_result;
  logic [3:0]   f_rsp0_flags, f_rsp1_flags;
  logic         f_rsp0_err, f_rsp1_err;
  logic [1:0]   f_grant;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W), .OP_W(3), .FIXED_PRIO(0), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .rsp0_valid(r_rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_result(r_rsp0_result),
    .rsp0_flags(r_rsp0_flags), .rsp0_err(r_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .rsp1_valid(r_rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_result(r_rsp1_result),
    .rsp1_flags(r_rsp1_flags), .rsp1_err(r_rsp1_err),
    .grant(r_grant)
  );

  alu_arbiter #(.DATA_W(W), .OP_W(3), .FIXED_PRIO(1), .STARVE_MAX(4)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .rsp0_valid(f_rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_result(f_rsp0_result),
    .rsp0_flags(f_rsp0_flags), .rsp0_err(f_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .rsp1_valid(f_rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_result(f_rsp1_result),
    .rsp1_flags(f_rsp1_flags), .rsp1_err(f_rsp1_err),
    .grant(f_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic rdy);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op; rsp0_ready = rdy;
  endtask

  task automatic drv1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic rdy);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op; rsp1_ready = rdy;
  endtask

  // advance to the drive point of the next cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv0(1'b0, '0, '0, 3'b000, 1'b0);
    drv1(1'b0, '0, '0, 3'b000, 1'b0);
    #3;
    chk("rst_rsp0_valid", r_rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", r_rsp1_valid, 1'b0);
    chk("rst_rsp0_result", r_rsp0_result, 32'h0);
    chk("rst_rsp1_flags", r_rsp1_flags, 4'h0);
    chk("rst_rsp0_err", r_rsp0_err, 1'b0);
    chk("rst_fp_rsp1_valid", f_rsp1_valid, 1'b0);
    chk("rst_grant", r_grant, 2'b00);
    next_cycle();
    rst = 1'b0;

    // ---- port 0 only: ADD 5 + 3, response held for 3 cycles ----
    next_cycle();
    drv0(1'b1, 32'h5, 32'h3, 3'b000, 1'b0);
    @(negedge clk);
    chk("add_grant", r_grant, 2'b01);
    chk("add_req0_ready", r_req0_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("hold_rsp0_valid", r_rsp0_valid, 1'b1);
      chk("hold_rsp0_result", r_rsp0_result, 32'h8);
      chk("hold_rsp0_flags", r_rsp0_flags, 4'b0000);
      chk("hold_req0_ready", r_req0_ready, 1'b0);
    end
    next_cycle();
    drv0(1'b0, '0, '0, 3'b000, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("drain_rsp0_valid", r_rsp0_valid, 1'b0);

    // reset so the first contention starts from port 0
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // ---- both ports continuously: RR alternates, FP gives port 1 every 5th ----
    next_cycle();
    drv0(1'b1, 32'h0, 32'h1, 3'b001, 1'b1);
    drv1(1'b1, 32'h7FFF_FFFF, 32'h1, 3'b000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rr_grant", r_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("fp_grant", f_grant, (i % 5 == 4) ? 2'b10 : 2'b01);
      if (i == 1) begin
        chk("rr_sub_valid", r_rsp0_valid, 1'b1);
        chk("rr_sub_result", r_rsp0_result, 32'hFFFF_FFFF);
        chk("rr_sub_flags", r_rsp0_flags, 4'b0101);
      end
      if (i == 2) begin
        chk("rr_add_valid", r_rsp1_valid, 1'b1);
        chk("rr_add_result", r_rsp1_result, 32'h8000_0000);
        chk("rr_add_flags", r_rsp1_flags, 4'b0110);
      end
      next_cycle();
    end
    drv0(1'b0, '0, '0, 3'b000, 1'b1);
    drv1(1'b0, '0, '0, 3'b000, 1'b1);
    next_cycle();
    next_cycle();

    // ---- port 1: SLT then illegal opcode 110 (drain + refill) ----
    drv1(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b101, 1'b0);
    @(negedge clk);
    chk("slt_grant", r_grant, 2'b10);
    next_cycle();
    drv1(1'b1, 32'h1234, 32'h5678, 3'b110, 1'b1);
    @(negedge clk);
    chk("slt_result", r_rsp1_result, 32'h1);
    chk("slt_flags", r_rsp1_flags, 4'b0000);
    chk("slt_err", r_rsp1_err, 1'b0);
    chk("ill_req1_ready", r_req1_ready, 1'b1);
    next_cycle();
    drv1(1'b0, '0, '0, 3'b000, 1'b0);
    @(negedge clk);
    chk("ill_valid", r_rsp1_valid, 1'b1);
    chk("ill_result", r_rsp1_result, 32'h0);
    chk("ill_flags", r_rsp1_flags, 4'b0000);
    chk("ill_err", r_rsp1_err, 1'b1);
    next_cycle();
    drv1(1'b0, '0, '0, 3'b000, 1'b1);
    next_cycle();
    drv1(1'b0, '0, '0, 3'b000, 1'b0);

    // ---- port 0 back-to-back: AND then OR, valid never drops ----
    drv0(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b010, 1'b1);
    @(negedge clk);
    chk("and_req0_ready", r_req0_ready, 1'b1);
    next_cycle();
    drv0(1'b1, 32'h1, 32'h2, 3'b011, 1'b1);
    @(negedge clk);
    chk("and_valid", r_rsp0_valid, 1'b1);
    chk("and_result", r_rsp0_result, 32'h0);
    chk("and_flags", r_rsp0_flags, 4'b1000);
    chk("or_req0_ready", r_req0_ready, 1'b1);
    next_cycle();
    drv0(1'b0, '0, '0, 3'b000, 1'b0);
    @(negedge clk);
    chk("or_valid", r_rsp0_valid, 1'b1);
    chk("or_result", r_rsp0_result, 32'h3);
    chk("or_flags", r_rsp0_flags, 4'b0000);

    // ---- fill both responses, then reset mid-stream ----
    next_cycle();
    drv0(1'b1, 32'h1, 32'h1, 3'b000, 1'b1);
    drv1(1'b1, 32'h2, 32'h2, 3'b000, 1'b0);
    next_cycle();
    drv0(1'b1, 32'h1, 32'h1, 3'b000, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("pre_rst_rsp0_valid", r_rsp0_valid, 1'b1);
    chk("pre_rst_rsp1_valid", r_rsp1_valid, 1'b1);
    chk("pre_rst_rsp1_result", r_rsp1_result, 32'h4);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp0_valid", r_rsp0_valid, 1'b0);
    chk("mid_rst_rsp1_valid", r_rsp1_valid, 1'b0);
    chk("mid_rst_rsp1_result", r_rsp1_result, 32'h0);
    chk("mid_rst_fp_rsp0_valid", f_rsp0_valid, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rr_grant", r_grant, 2'b01);
    chk("post_rst_fp_grant", f_grant, 2'b01);
    next_cycle();
    drv0(1'b0, '0, '0, 3'b000, 1'b0);
    drv1(1'b0, '0, '0, 3'b000, 1'b0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
